// File: rtl/quad_stepper_pkg.sv
// Shared definitions for the step/dir to quadrature encoder: phase encodings,
// quadrature sequencing and the pending-counter saturation limit.
package quad_stepper_pkg;

  typedef logic [1:0] phase_t;  // {A, B}

  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_10 = 2'b10;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_01 = 2'b01;

  // Forward walks 00->10->11->01->00 so a standard decoder counts up.
  function automatic phase_t next_phase(input phase_t phase, input logic fwd);
    phase_t nxt;
    case (phase)
      PH_00:   nxt = fwd ? PH_10 : PH_01;
      PH_10:   nxt = fwd ? PH_11 : PH_00;
      PH_11:   nxt = fwd ? PH_01 : PH_10;
      default: nxt = fwd ? PH_00 : PH_11;
    endcase
    return nxt;
  endfunction

  // Symmetric limit: pending stays within +/-(2^(bits-1)-1).
  function automatic int sat_limit(input int pending_bits);
    return (1 << (pending_bits - 1)) - 1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Three-flop synchronizer for an asynchronous level, with a one-cycle
// rising-edge pulse and the synchronized level taken from the same stage.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic level
);

  logic [2:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], async_in};
  end

  assign rise  = sync_q[1] & ~sync_q[2];
  assign level = sync_q[1];

endmodule

// File: rtl/quad_step_encoder.sv
// Converts step/dir pulses into a paced quadrature A/B pair, buffering bursts
// in a saturating signed pending counter.
module quad_step_encoder
  import quad_stepper_pkg::*;
#(
  parameter int DWELL_BITS   = 16,
  parameter int PENDING_BITS = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           step_in,
  input  logic                           dir_in,
  input  logic                           enable,
  input  logic [DWELL_BITS-1:0]          dwell,
  input  logic                           clear_overflow,
  output logic                           quadA,
  output logic                           quadB,
  output logic signed [PENDING_BITS-1:0] pending,
  output logic                           busy,
  output logic                           overflow
);

  localparam int SW = PENDING_BITS + 1;
  localparam logic signed [SW-1:0] LIM_POS = SW'(sat_limit(PENDING_BITS));
  localparam logic signed [SW-1:0] LIM_NEG = -LIM_POS;
  localparam logic signed [SW-1:0] ONE     = SW'(1);

  logic                   step_rise;
  logic                   step_level_unused;
  logic                   dir_rise_unused;
  logic                   dir_level;
  logic [DWELL_BITS-1:0]  timer;
  logic [DWELL_BITS-1:0]  dwell_load;
  phase_t                 phase;
  logic                   issue;
  logic                   issue_fwd;
  logic signed [SW-1:0]   sum_next;
  logic                   saturate;

  sync_edge_detect u_step_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (step_in),
    .rise     (step_rise),
    .level    (step_level_unused)
  );

  sync_edge_detect u_dir_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (dir_in),
    .rise     (dir_rise_unused),
    .level    (dir_level)
  );

  assign issue      = enable && (timer == '0) && (pending != '0);
  assign issue_fwd  = ~pending[PENDING_BITS-1];
  assign dwell_load = (dwell == '0) ? '0 : dwell - DWELL_BITS'(1);

  // Step and issue are folded into one sum so a coincident pair cancels exactly.
  always_comb begin
    // NOTE: default assignment first so every path drives sum_next and no latch is inferred.
    sum_next = {pending[PENDING_BITS-1], pending};
    if (step_rise) sum_next = dir_level ? sum_next + ONE : sum_next - ONE;
    if (issue)     sum_next = issue_fwd ? sum_next - ONE : sum_next + ONE;
  end

  assign saturate = (sum_next > LIM_POS) || (sum_next < LIM_NEG);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= '0;
      timer    <= '0;
      phase    <= PH_00;
      overflow <= 1'b0;
    end else begin
      if (!saturate) pending <= sum_next[PENDING_BITS-1:0];
      // A fresh drop outranks a clear arriving in the same cycle.
      if (saturate)            overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
      if (issue) begin
        phase <= next_phase(phase, issue_fwd);
        timer <= dwell_load;
      end else if (timer != '0) begin
        timer <= timer - DWELL_BITS'(1);
      end
    end
  end

  assign quadA = phase[1];
  assign quadB = phase[0];
  assign busy  = (pending != '0) || (timer != '0);

endmodule

// File: tb/tb_quad_step_encoder.sv
// Randomized and directed bench for quad_step_encoder against a cycle-level
// behavioural model and an independent quadrature position decoder.
module tb_quad_step_encoder;

  localparam int DW = 16;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                step_in = 1'b0, dir_in = 1'b1, enable = 1'b0, clear_overflow = 1'b0;
  logic [DW-1:0]       dwell = '0;
  logic                quadA, quadB, busy, overflow;
  logic signed [7:0]   pending;

  logic                step4 = 1'b0, dir4 = 1'b1, en4 = 1'b0, clr4 = 1'b0;
  logic                q4a, q4b, busy4, ovf4;
  logic signed [3:0]   pend4;

  int total = 0;
  int bad   = 0;
  bit mon_on = 1'b0;

  always #5 clk = ~clk;

  quad_step_encoder #(.DWELL_BITS(DW), .PENDING_BITS(8)) u_dut (
    .clk(clk), .reset(reset), .step_in(step_in), .dir_in(dir_in), .enable(enable),
    .dwell(dwell), .clear_overflow(clear_overflow), .quadA(quadA), .quadB(quadB),
    .pending(pending), .busy(busy), .overflow(overflow)
  );

  quad_step_encoder #(.DWELL_BITS(DW), .PENDING_BITS(4)) u_dut4 (
    .clk(clk), .reset(reset), .step_in(step4), .dir_in(dir4), .enable(en4),
    .dwell(dwell), .clear_overflow(clr4), .quadA(q4a), .quadB(q4b),
    .pending(pend4), .busy(busy4), .overflow(ovf4)
  );

  // Behavioural model: position is an integer, the AB pattern is derived from it.
  typedef struct {
    int       pending;
    int       timer;
    int       pos;
    bit       ovf;
    int       dropped;
    bit [2:0] sh;   // sh[k] = step level seen k+1 edges ago
    bit [2:0] dh;
  } model_t;

  model_t m8, m4;

  function automatic model_t model_step(input model_t m, input bit st, input bit dr,
                                        input bit en, input bit clr, input int dw,
                                        input int lim);
    bit ev, evdir, iss;
    int sgn, nxt;
    ev    = m.sh[1] && !m.sh[2];
    evdir = m.dh[1];
    iss   = en && (m.timer == 0) && (m.pending != 0);
    sgn   = (m.pending > 0) ? 1 : -1;
    nxt   = m.pending + (ev ? (evdir ? 1 : -1) : 0) - (iss ? sgn : 0);
    if (nxt > lim || nxt < -lim) begin
      m.ovf = 1'b1;
      m.dropped++;
    end else begin
      m.pending = nxt;
      if (clr) m.ovf = 1'b0;
    end
    if (iss) begin
      m.pos  += sgn;
      m.timer = ((dw == 0) ? 1 : dw) - 1;
    end else if (m.timer > 0) begin
      m.timer--;
    end
    m.sh = {m.sh[1:0], st};
    m.dh = {m.dh[1:0], dr};
    return m;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m8 = '{default: 0};
      m4 = '{default: 0};
    end else begin
      m8 = model_step(m8, step_in, dir_in, enable, clear_overflow, int'(dwell), 127);
      m4 = model_step(m4, step4, dir4, en4, clr4, int'(dwell), 7);
    end
  end

  function automatic logic [1:0] ab_of(input int pos);
    int k;
    k = ((pos % 4) + 4) % 4;
    case (k)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [11:0] exp8();
    return {ab_of(m8.pos), 8'(m8.pending), (m8.pending != 0 || m8.timer != 0), m8.ovf};
  endfunction

  function automatic logic [7:0] exp4();
    return {ab_of(m4.pos), 4'(m4.pending), (m4.pending != 0 || m4.timer != 0), m4.ovf};
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      total++;
      if ({quadA, quadB, pending, busy, overflow} !== exp8()) begin
        bad++;
        $display("FAIL model_track8 t=%0t got=%h want=%h", $time,
                 {quadA, quadB, pending, busy, overflow}, exp8());
      end
      total++;
      if ({q4a, q4b, pend4, busy4, ovf4} !== exp4()) begin
        bad++;
        $display("FAIL model_track4 t=%0t got=%h want=%h", $time,
                 {q4a, q4b, pend4, busy4, ovf4}, exp4());
      end
    end
  end

  // Independent downstream quadrature counter fed from the main DUT outputs.
  int         qpos = 0;
  int         qbad = 0;
  logic [1:0] qprev = 2'b00;

  function automatic int ab_idx(input logic [1:0] ab);
    case (ab)
      2'b10:   return 1;
      2'b11:   return 2;
      2'b01:   return 3;
      default: return 0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      qprev = 2'b00;
    end else begin
      int d;
      d = (ab_idx({quadA, quadB}) - ab_idx(qprev) + 4) % 4;
      if (d == 1)      qpos++;
      else if (d == 3) qpos--;
      else if (d == 2) qbad++;
      qprev = {quadA, quadB};
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input bit d, input int pre, input int hi, input int lo);
    dir_in = d;
    cyc(pre);
    step_in = 1'b1;
    cyc(hi);
    step_in = 1'b0;
    cyc(lo);
  endtask

  task automatic test_reset();
    cyc(2);
    total++;
    if ({quadA, quadB, pending, busy, overflow} !== 12'h0) begin
      bad++;
      $display("FAIL reset_hold got=%h want=000", {quadA, quadB, pending, busy, overflow});
    end
    reset = 1'b0;
    cyc(3);
    total++;
    if ({quadA, quadB, pending, busy, overflow, pend4, ovf4} !== 17'h0) begin
      bad++;
      $display("FAIL reset_release got=%h want=0",
               {quadA, quadB, pending, busy, overflow, pend4, ovf4});
    end
  endtask

  task automatic test_latency();
    logic [1:0] prev, want;
    dwell  = 16'd4;
    enable = 1'b1;
    dir_in = 1'b1;
    cyc(3);
    for (int k = 0; k < 3; k++) begin
      want = (k == 0) ? 2'b10 : (k == 1) ? 2'b11 : 2'b01;
      prev = {quadA, quadB};
      step_in = 1'b1;
      cyc(2);
      step_in = 1'b0;
      cyc(1);
      total++;
      if ({quadA, quadB} !== prev) begin
        bad++;
        $display("FAIL latency_early step=%0d got=%b want=%b", k, {quadA, quadB}, prev);
      end
      cyc(1);
      total++;
      if ({quadA, quadB} !== want) begin
        bad++;
        $display("FAIL latency_edge step=%0d got=%b want=%b", k, {quadA, quadB}, want);
      end
      cyc(2);
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL busy_hold step=%0d got=%b want=1", k, busy);
      end
      cyc(1);
      total++;
      if ({busy, pending} !== 9'h0) begin
        bad++;
        $display("FAIL busy_drop step=%0d got=%h want=000", k, {busy, pending});
      end
      cyc(13);
    end
  endtask

  task automatic test_burst();
    logic [1:0] prev;
    int maxp, edges, last, gap_err;
    maxp = 0; edges = 0; last = -1; gap_err = 0;
    dwell = 16'd10;
    dir_in = 1'b1;
    prev = {quadA, quadB};
    for (int c = 0; c < 80; c++) begin
      step_in = (c < 10) && (c % 2 == 0);
      @(negedge clk);
      if (int'(pending) > maxp) maxp = int'(pending);
      if ({quadA, quadB} !== prev) begin
        if (last >= 0 && c - last != 10) begin
          gap_err++;
          $display("note: edge gap %0d at cycle %0d", c - last, c);
        end
        last = c;
        edges++;
        prev = {quadA, quadB};
      end
    end
    total++;
    if (maxp != 4) begin
      bad++;
      $display("FAIL burst_peak got=%0d want=4", maxp);
    end
    total++;
    if (edges != 5) begin
      bad++;
      $display("FAIL burst_edges got=%0d want=5", edges);
    end
    total++;
    if (gap_err != 0) begin
      bad++;
      $display("FAIL burst_spacing got=%0d bad gaps want=0", gap_err);
    end
    total++;
    if ({quadA, quadB, busy} !== 3'b000) begin
      bad++;
      $display("FAIL burst_final got=%b want=000", {quadA, quadB, busy});
    end
  endtask

  task automatic test_disable();
    logic [1:0] prev;
    prev = {quadA, quadB};
    enable = 1'b0;
    for (int k = 0; k < 3; k++) pulse(1'b1, 2, 2, 2);
    cyc(2);
    total++;
    if (pending !== 8'sd3) begin
      bad++;
      $display("FAIL disable_accum got=%0d want=3", pending);
    end
    for (int k = 0; k < 3; k++) pulse(1'b0, 2, 2, 2);
    cyc(2);
    total++;
    if ({quadA, quadB, pending, busy} !== {prev, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL disable_cancel got=%h want=%h", {quadA, quadB, pending, busy},
               {prev, 8'h00, 1'b0});
    end
    enable = 1'b1;
    cyc(6);
    total++;
    if ({quadA, quadB, busy} !== {prev, 1'b0}) begin
      bad++;
      $display("FAIL reenable_quiet got=%b want=%b", {quadA, quadB, busy}, {prev, 1'b0});
    end
  endtask

  task automatic test_saturation();
    en4 = 1'b0;
    dir4 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step4 = 1'b1;
      cyc(2);
      step4 = 1'b0;
      cyc(3);
      total++;
      if (pend4 !== 4'((k < 7) ? k : 7) || ovf4 !== (k >= 8)) begin
        bad++;
        $display("FAIL sat_step%0d got pend=%0d ovf=%b want pend=%0d ovf=%b", k, pend4,
                 ovf4, (k < 7) ? k : 7, (k >= 8));
      end
    end
    clr4 = 1'b1;
    cyc(1);
    clr4 = 1'b0;
    cyc(1);
    total++;
    if ({pend4, ovf4} !== {4'sd7, 1'b0}) begin
      bad++;
      $display("FAIL ovf_clear got pend=%0d ovf=%b want pend=7 ovf=0", pend4, ovf4);
    end
    step4 = 1'b1;
    cyc(2);
    step4 = 1'b0;
    clr4  = 1'b1;
    cyc(1);
    clr4 = 1'b0;
    cyc(2);
    total++;
    if ({pend4, ovf4} !== {4'sd7, 1'b1}) begin
      bad++;
      $display("FAIL ovf_set_wins got pend=%0d ovf=%b want pend=7 ovf=1", pend4, ovf4);
    end
  endtask

  task automatic test_loopback();
    int fwd, rev, q0, drop0, waited;
    bit d;
    fwd = 0; rev = 0;
    dwell  = 16'd3;
    enable = 1'b1;
    q0     = qpos;
    drop0  = m8.dropped;
    for (int k = 0; k < 1000; k++) begin
      d = 1'($urandom_range(0, 1));
      if (d) fwd++;
      else   rev++;
      pulse(d, 2, 1, 1 + $urandom_range(0, 2));
    end
    waited = 0;
    while (busy !== 1'b0 && waited < 300) begin
      cyc(1);
      waited++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL loopback_drain got busy=%b after %0d clks want=0", busy, waited);
    end
    total++;
    if (qpos - q0 != fwd - rev - (m8.dropped - drop0)) begin
      bad++;
      $display("FAIL loopback_position got=%0d want=%0d", qpos - q0,
               fwd - rev - (m8.dropped - drop0));
    end
    total++;
    if (qbad != 0) begin
      bad++;
      $display("FAIL loopback_skips got=%0d want=0", qbad);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] prev;
    int waited;
    enable = 1'b0;
    dwell  = 16'd20;
    for (int k = 0; k < 6; k++) pulse(1'b1, 2, 2, 2);
    cyc(2);
    prev = {quadA, quadB};
    enable = 1'b1;
    waited = 0;
    do begin
      cyc(1);
      waited++;
    end while ({quadA, quadB} === prev && waited < 10);
    total++;
    if ({pending, busy} !== {8'sd5, 1'b1}) begin
      bad++;
      $display("FAIL midburst_state got pend=%0d busy=%b want pend=5 busy=1", pending, busy);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({quadA, quadB, pending, busy, overflow} !== 12'h0) begin
      bad++;
      $display("FAIL async_reset got=%h want=000", {quadA, quadB, pending, busy, overflow});
    end
    cyc(2);
    reset = 1'b0;
    cyc(2);
    pulse(1'b1, 2, 2, 2);
    cyc(2);
    total++;
    if ({quadA, quadB} !== 2'b10) begin
      bad++;
      $display("FAIL post_reset_edge got=%b want=10", {quadA, quadB});
    end
  endtask

  initial begin
    #1 reset = 1'b1;
    mon_on = 1'b1;
    test_reset();
    test_latency();
    test_burst();
    test_disable();
    test_saturation();
    test_loopback();
    test_reset_mid();
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t simulation did not complete", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
